// File: rtl/loopback_msg_tagger_if.sv
// Per-lane AXI-Stream bundle for the message tagger; PORT_COUNT lanes sit side by side
// in each packed vector, and lane i owns slice i of every field.
interface loopback_msg_tagger_if #(
    parameter int PORT_COUNT   = 2,
    parameter int DATA_WIDTH   = 64,
    parameter int STRB_WIDTH   = DATA_WIDTH/8,
    parameter int ID_TAG_WIDTH = 9
);
    logic [PORT_COUNT*DATA_WIDTH-1:0]   tdata;
    logic [PORT_COUNT*STRB_WIDTH-1:0]   tkeep;
    logic [PORT_COUNT-1:0]              tvalid;
    logic [PORT_COUNT-1:0]              tlast;
    logic [PORT_COUNT*ID_TAG_WIDTH-1:0] tdest;
    logic [PORT_COUNT-1:0]              tready;

    modport master (output tdata, tkeep, tvalid, tlast, tdest, input tready);
    modport slave  (input tdata, tkeep, tvalid, tlast, tdest, output tready);
endinterface

// File: rtl/loopback_msg_tagger.sv
// Prepends one header beat carrying the destination tag to every message on each
// independent AXI-Stream lane; the receiver side strips it back into tdest.
module loopback_msg_tagger #(
    parameter int DATA_WIDTH   = 64,
    parameter int STRB_WIDTH   = DATA_WIDTH/8,
    parameter int PORT_COUNT   = 2,
    parameter int CORE_WIDTH   = 4,
    parameter int ID_TAG_WIDTH = 5+CORE_WIDTH
) (
    input  logic                        clk,
    input  logic                        rst,
    loopback_msg_tagger_if.slave        s_axis,
    loopback_msg_tagger_if.master       m_axis,
    output logic [PORT_COUNT*32-1:0]    status_frames
);

    typedef enum logic {
        IDLE = 1'b0,
        BODY = 1'b1
    } state_t;

    state_t                 state_q [PORT_COUNT];
    state_t                 state_d [PORT_COUNT];

    logic [PORT_COUNT-1:0]  load_ok;
    logic [PORT_COUNT-1:0]  hdr_load;
    logic [PORT_COUNT-1:0]  beat_load;
    logic [PORT_COUNT-1:0]  s_ready;
    logic [DATA_WIDTH-1:0]  header_word [PORT_COUNT];

    logic [DATA_WIDTH-1:0]  or_data [PORT_COUNT];
    logic [STRB_WIDTH-1:0]  or_keep [PORT_COUNT];
    logic [PORT_COUNT-1:0]  or_last;
    logic [PORT_COUNT-1:0]  or_valid;
    logic [31:0]            frames [PORT_COUNT];

    always_ff @(posedge clk) begin
        for (int i = 0; i < PORT_COUNT; i++) begin
            if (rst) begin
                state_q[i] <= IDLE;
            end else begin
                state_q[i] <= state_d[i];
            end
        end
    end

    always_comb begin
        for (int i = 0; i < PORT_COUNT; i++) begin
            state_d[i] = state_q[i];
            case (state_q[i])
                IDLE:    if (hdr_load[i]) state_d[i] = BODY;
                BODY:    if (beat_load[i] && s_axis.tlast[i]) state_d[i] = IDLE;
                default: state_d[i] = IDLE;
            endcase
        end
    end

    // The first payload beat is left waiting upstream while the header goes out,
    // so IDLE never raises tready and the tag is only ever sampled from that beat.
    always_comb begin
        load_ok   = '0;
        s_ready   = '0;
        hdr_load  = '0;
        beat_load = '0;
        for (int i = 0; i < PORT_COUNT; i++) begin
            header_word[i] = '0;
        end
        for (int i = 0; i < PORT_COUNT; i++) begin
            load_ok[i]   = !or_valid[i] || m_axis.tready[i];
            s_ready[i]   = (state_q[i] == BODY) && load_ok[i];
            hdr_load[i]  = (state_q[i] == IDLE) && s_axis.tvalid[i] && load_ok[i];
            beat_load[i] = s_axis.tvalid[i] && s_ready[i];
            header_word[i][ID_TAG_WIDTH-1:0] = s_axis.tdest[i*ID_TAG_WIDTH +: ID_TAG_WIDTH];
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < PORT_COUNT; i++) begin
            if (rst) begin
                or_valid[i] <= 1'b0;
                or_last[i]  <= 1'b0;
                or_data[i]  <= '0;
                or_keep[i]  <= '0;
                frames[i]   <= '0;
            end else begin
                if (hdr_load[i]) begin
                    or_data[i]  <= header_word[i];
                    or_keep[i]  <= '1;
                    or_last[i]  <= 1'b0;
                    or_valid[i] <= 1'b1;
                end else if (beat_load[i]) begin
                    or_data[i]  <= s_axis.tdata[i*DATA_WIDTH +: DATA_WIDTH];
                    or_keep[i]  <= s_axis.tkeep[i*STRB_WIDTH +: STRB_WIDTH];
                    or_last[i]  <= s_axis.tlast[i];
                    or_valid[i] <= 1'b1;
                end else if (load_ok[i]) begin
                    or_valid[i] <= 1'b0;
                end
                if (or_valid[i] && m_axis.tready[i] && or_last[i]) begin
                    frames[i] <= frames[i] + 32'd1;
                end
            end
        end
    end

    // The tag travels inside the header beat, so the outgoing sideband stays zero.
    always_comb begin
        s_axis.tready = s_ready;
        m_axis.tvalid = or_valid;
        m_axis.tlast  = or_last;
        m_axis.tdest  = '0;
        m_axis.tdata  = '0;
        m_axis.tkeep  = '0;
        status_frames = '0;
        for (int i = 0; i < PORT_COUNT; i++) begin
            m_axis.tdata[i*DATA_WIDTH +: DATA_WIDTH] = or_data[i];
            m_axis.tkeep[i*STRB_WIDTH +: STRB_WIDTH] = or_keep[i];
            status_frames[i*32 +: 32]                = frames[i];
        end
    end

endmodule
